// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the five-stage core.
// Merges the ID load-use request, the EX divider handshake and the MEM
// exception/eret redirect into the per-stage stall bus and a registered
// one-cycle flush with its redirect target.
// Optional feature: define PIPE_DIV_TIMEOUT_EN to enable the divider wait
// watchdog (counter, DIV_MAX limit and sticky div_timeout flag).
module pipe_stall_ctrl #(
    parameter int STALL_W = 6,
    parameter int DIV_MAX = 33,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_id,
    input  logic               div_start,
    input  logic               div_ready,
    input  logic               excp_req,
    input  logic [31:0]        excp_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               div_busy,
    output logic               div_timeout
);

    // Hold patterns: load-use freezes PC..ID/EX, the divider also freezes EX/MEM.
    localparam logic [STALL_W-1:0] STALL_LU  = STALL_W'(3'b111);
    localparam logic [STALL_W-1:0] STALL_DIV = STALL_W'(4'b1111);

    // The wait counter must be able to represent the wait limit.
    if ((1 << CNT_W) <= DIV_MAX) begin : g_bad_cnt_w
        $error("pipe_stall_ctrl: CNT_W too small for DIV_MAX");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIVW  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [STALL_W-1:0] stall_raw;
    logic               timeout_now;

`ifdef PIPE_DIV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DIV_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_now = (wait_cnt == CNT_LIMIT);

    // Divider wait counter: cleared on entry or abort, saturating count while waiting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == ST_RUN && !excp_req && div_start) begin
            wait_cnt <= '0;
        end else if (state == ST_DIVW) begin
            if (excp_req) begin
                wait_cnt <= '0;
            end else if (!div_ready && wait_cnt != CNT_SAT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Sticky watchdog flag, set when the wait limit expires, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_timeout <= 1'b0;
        end else if (state == ST_DIVW && !excp_req && !div_ready && timeout_now) begin
            div_timeout <= 1'b1;
        end
    end
`else
    assign timeout_now = 1'b0;
    assign div_timeout = 1'b0;
`endif

    // State register; reset forces RUN immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and stall decode; excp_req outranks every other request.
    always_comb begin
        next_state = state;
        stall_raw  = '0;
        case (state)
            ST_RUN: begin
                if (excp_req) begin
                    next_state = ST_FLUSH;
                end else if (div_start) begin
                    next_state = ST_DIVW;
                    stall_raw  = STALL_DIV;
                end else if (stallreq_id) begin
                    stall_raw  = STALL_LU;
                end
            end
            ST_DIVW: begin
                if (excp_req) begin
                    next_state = ST_FLUSH;
                end else if (div_ready) begin
                    next_state = ST_RUN;
                    if (stallreq_id) begin
                        stall_raw = STALL_LU;
                    end
                end else if (timeout_now) begin
                    next_state = ST_RUN;
                end else begin
                    stall_raw  = STALL_DIV;
                end
            end
            ST_FLUSH: begin
                next_state = excp_req ? ST_FLUSH : ST_RUN;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    // Registered flush pulse and redirect target, captured from any state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush  <= 1'b0;
            new_pc <= 32'h0;
        end else begin
            flush <= excp_req;
            if (excp_req) begin
                new_pc <= excp_pc;
            end
        end
    end

    assign stall    = resetn ? stall_raw : '0;
    assign div_busy = (state == ST_DIVW);

endmodule
